// File: rtl/timer_scheduler_pkg.sv
// Shared types and helpers for the timer scheduler: FSM state encoding and
// the round-robin index width.
package timer_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } sched_state_e;

    // Keeps the owner/pointer registers at least one bit wide.
    function automatic int rr_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/timer_scheduler_if.sv
// Requester-side bundle of the timer scheduler: level requests with their
// intervals in, grant/done/busy and the live counter out.
interface timer_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] interval;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic [WIDTH-1:0]         count;

    modport master (
        output req, interval,
        input  grant, done, busy, count
    );

    modport slave (
        input  req, interval,
        output grant, done, busy, count
    );
endinterface

// File: rtl/timer_scheduler_interval_counter.sv
// Shared interval up-counter: synchronous clear has priority over enable;
// hit flags the terminal value for the scheduler FSM.
module interval_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             enb_i,
    input  logic [WIDTH-1:0] target_i,
    output logic [WIDTH-1:0] count_o,
    output logic             hit_o
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (enb_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign hit_o   = (count_q == target_i);
endmodule

// File: rtl/timer_scheduler.sv
// Round-robin owner of one shared interval counter; the granted requester's
// interval is run out and answered with a single-cycle done pulse.
//   state  | meaning
//   IDLE   | no owner; pick the next requester at or after rr_ptr
//   RUN    | counting 0..target for the owner; withdrawal aborts
//   FINISH | done pulse to the owner, grant still held
module timer_scheduler
    import timer_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    timer_scheduler_if.slave bus
);
    localparam int IDX_W = rr_idx_w(NUM_REQ);

    sched_state_e       state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]   target_q, target_d;
    logic [IDX_W-1:0]   pick_idx, next_ptr;
    logic               pick_found;
    logic               cnt_clr, cnt_enb, cnt_hit;
    logic [WIDTH-1:0]   cnt_val;

    // Masked pass from rr_ptr upward, then unmasked fallback for the wrap.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && bus.req[i] && (i >= int'(rr_ptr_q))) begin
                pick_idx   = i[IDX_W-1:0];
                pick_found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && bus.req[i]) begin
                pick_idx   = i[IDX_W-1:0];
                pick_found = 1'b1;
            end
        end
    end

    assign next_ptr = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        target_d = target_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d           = RUN;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    owner_d           = pick_idx;
                    target_d          = bus.interval[pick_idx*WIDTH +: WIDTH];
                end
            end
            RUN: begin
                // Withdrawal wins even on the terminal cycle: no done is owed.
                if (!bus.req[owner_q]) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                end else if (cnt_hit) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d  = IDLE;
                grant_d  = '0;
                rr_ptr_d = next_ptr;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            target_q <= target_d;
        end
    end

    // Counter holds at target in FINISH so it never passes the interval.
    assign cnt_enb = (state_q == RUN) && !cnt_hit;
    assign cnt_clr = (state_d != state_q) && (state_d != FINISH);

    interval_counter #(.WIDTH(WIDTH)) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (cnt_clr),
        .enb_i    (cnt_enb),
        .target_i (target_q),
        .count_o  (cnt_val),
        .hit_o    (cnt_hit)
    );

    assign bus.grant = grant_q;
    assign bus.done  = (state_q == FINISH) ? grant_q : '0;
    assign bus.busy  = (state_q != IDLE);
    assign bus.count = cnt_val;
endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler: an elapsed-time model of the scheduler
// is compared on every falling edge, with literal checks on key timings.
module tb_timer_scheduler;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    timer_scheduler_if #(.NUM_REQ(N), .WIDTH(W)) bus ();
    timer_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: owner index (-1 idle), cycles since grant, latched target, rr pointer.
    int m_owner   = -1;
    int m_elapsed = 0;
    int m_target  = 0;
    int m_ptr     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_elapsed = 0; m_target = 0; m_ptr = 0;
        end else if (m_owner < 0) begin
            if (|bus.req) begin
                m_owner   = rr_pick(bus.req, m_ptr);
                m_elapsed = 0;
                m_target  = int'(bus.interval[m_owner*W +: W]);
            end
        end else if (m_elapsed == m_target + 1 || !bus.req[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else begin
            m_elapsed++;
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] eg;
        logic [N-1:0] ed;
        int ec;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        ed = (m_owner >= 0 && m_elapsed == m_target + 1) ? eg : '0;
        ec = (m_owner < 0) ? 0 : ((m_elapsed < m_target) ? m_elapsed : m_target);
        chk("model_grant", 32'(bus.grant), 32'(eg));
        chk("model_done",  32'(bus.done),  32'(ed));
        chk("model_busy",  32'(bus.busy),  32'(m_owner >= 0));
        chk("model_count", 32'(bus.count), 32'(ec));
    end

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.grant))
        else begin n_fail++; $display("FAIL sva_onehot0: grant=%b", bus.grant); end
    a_done_sub: assert property (@(posedge clk) disable iff (!rst_n) (bus.done & ~bus.grant) == '0)
        else begin n_fail++; $display("FAIL sva_done_subset: done=%b grant=%b", bus.done, bus.grant); end
    a_busy: assert property (@(posedge clk) disable iff (!rst_n) bus.busy == (|bus.grant))
        else begin n_fail++; $display("FAIL sva_busy: busy=%b grant=%b", bus.busy, bus.grant); end

    task automatic set_iv(input int i, input int v);
        bus.interval[i*W +: W] = W'(v);
    endtask

    task automatic wait_grant(input int budget, output int who);
        who = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (bus.grant != '0) begin
                for (int j = 0; j < N; j++) if (bus.grant[j]) who = j;
                return;
            end
        end
        timeout("wait_grant");
    endtask

    task automatic wait_done(input int budget, output int lat, output logic [N-1:0] d,
                             output int cnt_at_done, output int cnt_max);
        lat = -1; d = '0; cnt_at_done = -1; cnt_max = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (int'(bus.count) > cnt_max) cnt_max = int'(bus.count);
            if (bus.done != '0) begin
                lat = k; d = bus.done; cnt_at_done = int'(bus.count);
                return;
            end
        end
        timeout("wait_done");
    endtask

    task automatic wait_count(input int val, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (int'(bus.count) == val) return;
            @(negedge clk);
        end
        timeout("wait_count");
    endtask

    initial begin
        int who, lat, cad, cmax;
        logic [N-1:0] d;
        int exp_order[5] = '{0, 1, 2, 3, 0};

        rst_n = 1'b0;
        bus.req = '0;
        bus.interval = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_busy",  32'(bus.busy),  32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_done",  32'(bus.done),  32'd0);
        rst_n = 1'b1;

        // Single request, interval 5
        @(negedge clk);
        set_iv(2, 5);
        bus.req = 4'b0100;
        @(negedge clk);
        chk("t1_grant", 32'(bus.grant), 32'b0100);
        wait_done(20, lat, d, cad, cmax);
        chk("t1_latency", 32'(lat), 32'd6);
        chk("t1_done", 32'(d), 32'b0100);
        bus.req = '0;
        @(negedge clk);
        chk("t1_release", 32'(bus.grant), 32'd0);

        // Zero interval
        set_iv(0, 0);
        bus.req = 4'b0001;
        @(negedge clk);
        chk("t2_grant", 32'(bus.grant), 32'b0001);
        wait_done(10, lat, d, cad, cmax);
        chk("t2_latency", 32'(lat), 32'd1);
        bus.req = '0;
        @(negedge clk);

        // Round robin from a fresh pointer
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_iv(i, 3);
        bus.req = 4'hF;
        for (int g = 0; g < 5; g++) begin
            wait_grant(20, who);
            chk("t3_order", 32'(who), 32'(exp_order[g]));
            wait_done(20, lat, d, cad, cmax);
            chk("t3_latency", 32'(lat), 32'd4);
            if (who >= 0) bus.req[who] = 1'b0;
            @(negedge clk);
            chk("t3_gap", 32'(bus.grant), 32'd0);
            if (who >= 0) bus.req[who] = 1'b1;
        end
        bus.req = '0;
        @(negedge clk);

        // Withdrawal at count 7 with req[3] pending
        set_iv(1, 20);
        set_iv(3, 2);
        bus.req = 4'b1010;
        wait_grant(10, who);
        chk("t4_first", 32'(who), 32'd1);
        wait_count(7, 30);
        bus.req[1] = 1'b0;
        @(negedge clk);
        chk("t4_drop_grant", 32'(bus.grant), 32'd0);
        chk("t4_drop_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        chk("t4_next_grant", 32'(bus.grant), 32'b1000);
        wait_done(10, lat, d, cad, cmax);
        chk("t4_done", 32'(d), 32'b1000);
        bus.req = '0;
        @(negedge clk);

        // Maximum interval
        set_iv(0, 255);
        bus.req = 4'b0001;
        wait_grant(10, who);
        chk("t5_grant", 32'(who), 32'd0);
        wait_done(300, lat, d, cad, cmax);
        chk("t5_latency", 32'(lat), 32'd256);
        chk("t5_count_at_done", 32'(cad), 32'd255);
        chk("t5_count_peak", 32'(cmax), 32'd255);
        bus.req = '0;
        @(negedge clk);

        // Asynchronous reset mid-run
        set_iv(2, 30);
        set_iv(0, 4);
        bus.req = 4'b0101;
        wait_grant(10, who);
        chk("t6_first", 32'(who), 32'd2);
        wait_count(10, 40);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_grant", 32'(bus.grant), 32'd0);
        chk("t6_busy",  32'(bus.busy),  32'd0);
        chk("t6_count", 32'(bus.count), 32'd0);
        chk("t6_done",  32'(bus.done),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_after_reset", 32'(bus.grant), 32'b0001);
        bus.req = '0;
        repeat (8) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
